// File: rtl/cam_model_pkg.sv
// Shared types and constants for the parallel camera sensor model:
// FSM states, test-pattern modes and the colour-bar palette.
package cam_model_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    HBLANK,
    VFRONT
  } camState_e;

  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_XOR   = 2'd3
  } camMode_e;

  // RGB565: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [15:0] BAR_COLOR [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  // Counter width for values 0..v-1, never narrower than one bit.
  function automatic int clogMin1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/cam_pclk_div.sv
// PCLK generator: free-running divider; tick marks the PCLK falling edge,
// which is where the sensor updates VSYNC, HREF and D.
module cam_pclk_div
  import cam_model_pkg::*;
#(
  parameter int PCLK_DIV = 1
) (
  input  logic mclk,
  input  logic reset,
  output logic pclk,
  output logic tick
);

  localparam int DW = clogMin1(2 * PCLK_DIV);

  logic [DW-1:0] divCnt;

  assign tick = (divCnt == DW'(2 * PCLK_DIV - 1));
  assign pclk = (divCnt >= DW'(PCLK_DIV));

  // NOTE: sequential state is always written with non-blocking assignments.
  always_ff @(posedge mclk) begin
    if (reset)     divCnt <= '0;
    else if (tick) divCnt <= '0;
    else           divCnt <= divCnt + 1'b1;
  end

endmodule

// File: rtl/cam_sensor_model.sv
// OV7670-style 8-bit parallel camera model: VSYNC/HREF/PCLK/D frame generator
// with selectable test patterns plus frame-done and frame-count status.
module cam_sensor_model
  import cam_model_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int BPP         = 2,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int PCLK_DIV    = 1,
  parameter int BAR_SHIFT   = 6
) (
  input  logic        xipMCLK,
  input  logic        xipRESET,
  input  logic        xipEN,
  input  logic [1:0]  xipMODE,
  input  logic [7:0]  xipCONST,
  output logic        xopCAM_PCLK,
  output logic        xopCAM_VSYNC,
  output logic        xopCAM_HREF,
  output logic [7:0]  xopCAM_D,
  output logic        xopFRAME_DONE,
  output logic [15:0] xopFRAME_CNT
);

  localparam int LINE_BYTES = H_ACTIVE * BPP;
  localparam int LINE_TICKS = LINE_BYTES + H_BLANK;
  localparam int VMAX_A     = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int VMAX       = (VMAX_A > V_FRONT) ? VMAX_A : V_FRONT;
  localparam int HW         = clogMin1(LINE_TICKS);
  localparam int VW         = clogMin1(VMAX);
  localparam int YW         = clogMin1(V_ACTIVE);

  logic          tick;
  camState_e     state;
  logic [HW-1:0] hCnt;
  logic [VW-1:0] vCnt;
  logic [YW-1:0] yCnt;
  camMode_e      modeLat;
  logic [7:0]    constLat;

  cam_pclk_div #(.PCLK_DIV(PCLK_DIV)) uDiv (
    .mclk  (xipMCLK),
    .reset (xipRESET),
    .pclk  (xopCAM_PCLK),
    .tick  (tick)
  );

  logic lineEnd, activeEnd, hblankEnd, lastActiveLine, frameEnd;

  assign lineEnd        = (hCnt == HW'(LINE_TICKS - 1));
  assign activeEnd      = (hCnt == HW'(LINE_BYTES - 1));
  assign hblankEnd      = (hCnt == HW'(H_BLANK - 1));
  assign lastActiveLine = (yCnt == YW'(V_ACTIVE - 1));
  // With no front porch the frame ends on the last HBLANK tick instead.
  assign frameEnd = tick &&
    ((state == VFRONT && lineEnd && vCnt == VW'(V_FRONT - 1)) ||
     (V_FRONT == 0 && state == HBLANK && hblankEnd && lastActiveLine));

  function automatic logic [7:0] pixelByte(input logic [HW-1:0] b,
                                           input logic [YW-1:0] y);
    logic [HW-1:0] x;
    logic [15:0]   color;
    logic          lowByte;
    x         = (BPP == 2) ? (b >> 1) : b;
    color     = BAR_COLOR[3'(x >> BAR_SHIFT)];
    lowByte   = (BPP == 2) && b[0];
    pixelByte = 8'h00;
    case (modeLat)
      MODE_RAMP:  pixelByte = 8'(b);
      MODE_BARS:  pixelByte = lowByte ? color[7:0] : color[15:8];
      MODE_CONST: pixelByte = constLat;
      MODE_XOR:   pixelByte = xopFRAME_CNT[7:0] ^ 8'(y);
      default:    pixelByte = 8'h00;
    endcase
  endfunction

  always_ff @(posedge xipMCLK) begin
    xopFRAME_DONE <= 1'b0;
    if (xipRESET) begin
      state        <= IDLE;
      hCnt         <= '0;
      vCnt         <= '0;
      yCnt         <= '0;
      modeLat      <= MODE_RAMP;
      constLat     <= 8'h00;
      xopCAM_VSYNC <= 1'b0;
      xopCAM_HREF  <= 1'b0;
      xopCAM_D     <= 8'h00;
      xopFRAME_CNT <= 16'h0000;
    end else if (frameEnd) begin
      xopFRAME_DONE <= 1'b1;
      xopFRAME_CNT  <= xopFRAME_CNT + 16'd1;
      hCnt          <= '0;
      vCnt          <= '0;
      yCnt          <= '0;
      xopCAM_HREF   <= 1'b0;
      xopCAM_D      <= 8'h00;
      if (xipEN) begin
        state        <= VSYNC;
        xopCAM_VSYNC <= 1'b1;
        modeLat      <= camMode_e'(xipMODE);
        constLat     <= xipCONST;
      end else begin
        state        <= IDLE;
        xopCAM_VSYNC <= 1'b0;
      end
    end else if (tick) begin
      case (state)
        IDLE: if (xipEN) begin
          state        <= VSYNC;
          xopCAM_VSYNC <= 1'b1;
          modeLat      <= camMode_e'(xipMODE);
          constLat     <= xipCONST;
          hCnt         <= '0;
          vCnt         <= '0;
        end
        VSYNC: begin
          hCnt <= lineEnd ? '0 : hCnt + 1'b1;
          if (lineEnd && vCnt == VW'(VSYNC_LINES - 1)) begin
            vCnt         <= '0;
            xopCAM_VSYNC <= 1'b0;
            if (V_BACK > 0) begin
              state <= VBACK;
            end else begin
              state       <= ACTIVE;
              xopCAM_HREF <= 1'b1;
              xopCAM_D    <= pixelByte('0, '0);
            end
          end else if (lineEnd) begin
            vCnt <= vCnt + 1'b1;
          end
        end
        VBACK: begin
          hCnt <= lineEnd ? '0 : hCnt + 1'b1;
          if (lineEnd && vCnt == VW'(V_BACK - 1)) begin
            vCnt        <= '0;
            state       <= ACTIVE;
            xopCAM_HREF <= 1'b1;
            xopCAM_D    <= pixelByte('0, '0);
          end else if (lineEnd) begin
            vCnt <= vCnt + 1'b1;
          end
        end
        ACTIVE: begin
          if (activeEnd) begin
            state       <= HBLANK;
            hCnt        <= '0;
            xopCAM_HREF <= 1'b0;
            xopCAM_D    <= 8'h00;
          end else begin
            hCnt     <= hCnt + 1'b1;
            xopCAM_D <= pixelByte(hCnt + 1'b1, yCnt);
          end
        end
        HBLANK: begin
          if (hblankEnd) begin
            hCnt <= '0;
            if (lastActiveLine) begin
              yCnt  <= '0;
              state <= VFRONT;
            end else begin
              yCnt        <= yCnt + 1'b1;
              state       <= ACTIVE;
              xopCAM_HREF <= 1'b1;
              xopCAM_D    <= pixelByte('0, yCnt + 1'b1);
            end
          end else begin
            hCnt <= hCnt + 1'b1;
          end
        end
        VFRONT: begin
          hCnt <= lineEnd ? '0 : hCnt + 1'b1;
          if (lineEnd) vCnt <= vCnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_sensor_model.sv
// Self-checking bench for cam_sensor_model: a frame-position reference model
// predicts every output each MCLK, plus directed byte-sequence checks.
module tb_cam_sensor_model;

  localparam int H_ACTIVE    = 4;
  localparam int V_ACTIVE    = 2;
  localparam int BPP         = 2;
  localparam int H_BLANK     = 2;
  localparam int VSYNC_LINES = 1;
  localparam int V_BACK      = 1;
  localparam int V_FRONT     = 1;
  localparam int PCLK_DIV    = 1;
  localparam int BAR_SHIFT   = 1;

  localparam int LINE_TICKS  = H_ACTIVE * BPP + H_BLANK;
  localparam int FRAME_TICKS = LINE_TICKS * (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT);

  logic        clk = 1'b0;
  logic        rst, en;
  logic [1:0]  mode;
  logic [7:0]  cnst;
  logic        xopCAM_PCLK, xopCAM_VSYNC, xopCAM_HREF, xopFRAME_DONE;
  logic [7:0]  xopCAM_D;
  logic [15:0] xopFRAME_CNT;

  always #5 clk = ~clk;

  cam_sensor_model #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .BPP(BPP), .H_BLANK(H_BLANK),
    .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT),
    .PCLK_DIV(PCLK_DIV), .BAR_SHIFT(BAR_SHIFT)
  ) dut (
    .xipMCLK       (clk),
    .xipRESET      (rst),
    .xipEN         (en),
    .xipMODE       (mode),
    .xipCONST      (cnst),
    .xopCAM_PCLK   (xopCAM_PCLK),
    .xopCAM_VSYNC  (xopCAM_VSYNC),
    .xopCAM_HREF   (xopCAM_HREF),
    .xopCAM_D      (xopCAM_D),
    .xopFRAME_DONE (xopFRAME_DONE),
    .xopFRAME_CNT  (xopFRAME_CNT)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: position within the frame, counted in PCLK ticks.
  int  mPhase = 0, mT = 0, mFrames = 0, mMode = 0, mConst = 0;
  bit  mRun = 0, mDone = 0;
  int  cycNum = 0;
  logic [7:0] capQ[$];
  int  doneCyc[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cycNum);
    end
  endtask

  function automatic int barColor(input int bar);
    case (bar)
      0: return 'hFFFF;  1: return 'hFFE0;  2: return 'h07FF;  3: return 'h07E0;
      4: return 'hF81F;  5: return 'hF800;  6: return 'h001F;  default: return 'h0000;
    endcase
  endfunction

  function automatic int refByte(input int col, input int y);
    int color;
    case (mMode)
      0: return col % 256;
      1: begin
        color = barColor(((col / BPP) >> BAR_SHIFT) % 8);
        return (BPP == 2 && col % 2 == 1) ? (color % 256) : (color / 256);
      end
      2: return mConst;
      default: return (mFrames ^ y) % 256;
    endcase
  endfunction

  task automatic cycle();
    bit tickNow;
    int line, col, y, exD;
    bit exV, exH;
    @(posedge clk);
    cycNum++;
    if (rst) begin
      mPhase = 0; mRun = 0; mT = 0; mFrames = 0; mDone = 0;
    end else begin
      tickNow = (mPhase == 2 * PCLK_DIV - 1);
      mPhase  = tickNow ? 0 : mPhase + 1;
      mDone   = 0;
      if (tickNow) begin
        if (!mRun) begin
          if (en) begin mRun = 1; mT = 0; mMode = int'(mode); mConst = int'(cnst); end
        end else if (mT == FRAME_TICKS - 1) begin
          mDone   = 1;
          mFrames = (mFrames + 1) % 65536;
          if (en) begin mT = 0; mMode = int'(mode); mConst = int'(cnst); end
          else mRun = 0;
        end else begin
          mT++;
        end
      end
    end
    @(negedge clk);
    exV = 0; exH = 0; exD = 0;
    if (mRun) begin
      line = mT / LINE_TICKS;
      col  = mT % LINE_TICKS;
      y    = line - VSYNC_LINES - V_BACK;
      exV  = (line < VSYNC_LINES);
      exH  = (y >= 0) && (y < V_ACTIVE) && (col < H_ACTIVE * BPP);
      exD  = exH ? refByte(col, y) : 0;
    end
    check("pclk",  16'(xopCAM_PCLK),   16'(mPhase >= PCLK_DIV));
    check("vsync", 16'(xopCAM_VSYNC),  16'(exV));
    check("href",  16'(xopCAM_HREF),   16'(exH));
    check("data",  16'(xopCAM_D),      16'(exD));
    check("done",  16'(xopFRAME_DONE), 16'(mDone));
    check("fcnt",  xopFRAME_CNT,       16'(mFrames));
    if (xopCAM_PCLK && xopCAM_HREF) capQ.push_back(xopCAM_D);
    if (xopFRAME_DONE) doneCyc.push_back(cycNum);
  endtask

  task automatic runToDone(input int budget);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (xopFRAME_DONE !== 1'b1 && n < budget);
    check("done_wait", 16'(xopFRAME_DONE), 16'd1);
  endtask

  logic [7:0] barSeq [8];
  logic [7:0] rndConst;

  initial begin
    barSeq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'hFF, 8'hE0};
    rst = 1'b1; en = 1'b0; mode = 2'd0; cnst = 8'h00;

    // Reset, then idle with EN low.
    repeat (5) cycle();
    rst = 1'b0;
    repeat (200) cycle();
    check("idle_cnt", xopFRAME_CNT, 16'd0);
    check("idle_done_pulses", 16'(doneCyc.size()), 16'd0);

    // First frame, byte ramp.
    en = 1'b1; mode = 2'd0;
    capQ.delete();
    runToDone(300);
    check("ramp_bytes", 16'(capQ.size()), 16'(2 * H_ACTIVE * BPP));
    for (int i = 0; i < capQ.size() && i < 16; i++)
      check("ramp_byte", 16'(capQ[i]), 16'(i % 8));
    check("f1_cnt", xopFRAME_CNT, 16'd1);
    check("vsync_after_done", 16'(xopCAM_VSYNC), 16'd1);

    // Back-to-back frames.
    runToDone(300);
    runToDone(300);
    check("f3_cnt", xopFRAME_CNT, 16'd3);
    check("done_count", 16'(doneCyc.size()), 16'd3);
    if (doneCyc.size() >= 3) begin
      check("frame_period_a", 16'(doneCyc[1] - doneCyc[0]), 16'd100);
      check("frame_period_b", 16'(doneCyc[2] - doneCyc[1]), 16'd100);
    end

    // Colour bars latched for frame 5.
    mode = 2'd1;
    runToDone(300);
    capQ.delete();
    mode = 2'd3;
    runToDone(300);
    check("bar_bytes", 16'(capQ.size()), 16'd16);
    for (int i = 0; i < capQ.size() && i < 16; i++)
      check("bar_byte", 16'(capQ[i]), 16'(barSeq[i % 8]));
    check("f5_cnt", xopFRAME_CNT, 16'd5);

    // Frame^line at FRAME_CNT=5; mid-frame switch to constant is deferred.
    capQ.delete();
    repeat (30) cycle();
    rndConst = 8'($urandom);
    mode = 2'd2; cnst = rndConst;
    runToDone(300);
    check("xor_bytes", 16'(capQ.size()), 16'd16);
    for (int i = 0; i < capQ.size() && i < 16; i++)
      check("xor_byte", 16'(capQ[i]), (i < 8) ? 16'h05 : 16'h04);
    capQ.delete();
    cnst = ~rndConst;
    runToDone(300);
    check("const_bytes", 16'(capQ.size()), 16'd16);
    for (int i = 0; i < capQ.size() && i < 16; i++)
      check("const_byte", 16'(capQ[i]), 16'(rndConst));

    // Randomised mode/const/enable changes against the model.
    for (int k = 0; k < 8; k++) begin
      mode = 2'($urandom_range(0, 3));
      cnst = 8'($urandom);
      en   = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(20, 150)) cycle();
    end

    // EN dropped mid-ACTIVE: frame completes, then IDLE.
    en = 1'b1; mode = 2'd0;
    runToDone(300);
    repeat (45) cycle();
    check("en_drop_href", 16'(xopCAM_HREF), 16'd1);
    en = 1'b0;
    runToDone(200);
    repeat (40) cycle();
    check("idle_after_drop", 16'(xopCAM_VSYNC), 16'd0);

    // Reset mid-line clears every output on the next cycle.
    en = 1'b1;
    repeat (50) cycle();
    rst = 1'b1;
    cycle();
    check("rst_pclk",  16'(xopCAM_PCLK),   16'd0);
    check("rst_vsync", 16'(xopCAM_VSYNC),  16'd0);
    check("rst_href",  16'(xopCAM_HREF),   16'd0);
    check("rst_data",  16'(xopCAM_D),      16'd0);
    check("rst_done",  16'(xopFRAME_DONE), 16'd0);
    check("rst_cnt",   xopFRAME_CNT,       16'd0);
    rst = 1'b0;
    repeat (20) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
